// File: rtl/ysyx_22050612_pkg.sv
// Shared types and constants for the ysyx_22050612 fetch path.
package ysyx_22050612_pkg;
    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam logic [ILEN-1:0] NOP_INST         = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h8000_0000;

    typedef struct packed {
        logic [ILEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_BUSY,
        FETCH_DROP
    } fetch_state_e;
endpackage

// File: rtl/ysyx_22050612_ifu_if.sv
// Instruction-memory request/response channel between the IFU and memory.
interface ysyx_22050612_ifu_if
    import ysyx_22050612_pkg::*;
;
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            rsp_valid;
    logic [ILEN-1:0] rsp_data;
    logic            rsp_err;

    modport master (
        output req_valid, req_addr,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_addr,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/ysyx_22050612_ifu_fifo.sv
// Synchronous fetch-entry FIFO with flush and occupancy count.
module ysyx_22050612_ifu_fifo
    import ysyx_22050612_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  fetch_entry_t     push_data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output fetch_entry_t     head_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    fetch_entry_t     buf_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && (cnt_q != '0);
    assign do_push = push_i && !flush_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Storage needs no reset: the head is only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (do_push) buf_q[wr_ptr_q] <= push_data_i;
    end

    assign valid_o = (cnt_q != '0);
    assign head_o  = buf_q[rd_ptr_q];
    assign count_o = cnt_q;

    no_push_when_full: assert property (@(posedge clk) disable iff (rst)
        !(do_push && !do_pop && (cnt_q == FULL_CNT)));
endmodule

// File: rtl/ysyx_22050612_ifu.sv
// Instruction fetch unit: owns the PC, fetches one word at a time from
// instruction memory and buffers {inst, pc} for the decode stage.
module ysyx_22050612_ifu
    import ysyx_22050612_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    ysyx_22050612_ifu_if.master mem,
    input  logic                halt_i,
    input  logic                redirect_valid_i,
    input  logic [XLEN-1:0]     redirect_pc_i,
    output logic                inst_valid_o,
    input  logic                inst_ready_i,
    output logic [ILEN-1:0]     inst_o,
    output logic [XLEN-1:0]     inst_pc_o,
    output logic                fault_o,
    output logic [XLEN-1:0]     fault_pc_o
);
    localparam int               CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    fetch_state_e     state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  req_pc_q, req_pc_d;
    logic [XLEN-1:0]  fault_pc_q, fault_pc_d;
    logic             fault_q, fault_d;
    logic             req_fire, rsp_live, push, pop, head_valid;
    logic [CNT_W-1:0] fifo_count;
    fetch_entry_t     push_entry, head_entry;

    // Issue only when idle and a buffer slot is guaranteed for the response.
    assign mem.req_valid = !rst && !halt_i && !fault_q && !redirect_valid_i
                           && (state_q == FETCH_IDLE) && (fifo_count < DEPTH_CNT);
    assign mem.req_addr  = pc_q;
    assign req_fire      = mem.req_valid && mem.req_ready;
    assign rsp_live      = mem.rsp_valid && (state_q == FETCH_BUSY) && !redirect_valid_i;
    assign push          = rsp_live && !mem.rsp_err;
    assign pop           = head_valid && inst_ready_i;
    assign push_entry    = '{inst: mem.rsp_data, pc: req_pc_q};

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;

        // FETCH_DROP marks an in-flight response that belongs to a stale stream.
        case (state_q)
            FETCH_IDLE: if (req_fire) begin
                state_d  = FETCH_BUSY;
                req_pc_d = pc_q;
            end
            FETCH_BUSY: begin
                if (mem.rsp_valid)         state_d = FETCH_IDLE;
                else if (redirect_valid_i) state_d = FETCH_DROP;
            end
            FETCH_DROP: if (mem.rsp_valid) state_d = FETCH_IDLE;
            default:    state_d = FETCH_IDLE;
        endcase

        if (req_fire) pc_d = pc_q + 64'd4;

        if (rsp_live && mem.rsp_err) begin
            fault_d    = 1'b1;
            fault_pc_d = req_pc_q;
        end

        if (redirect_valid_i) begin
            pc_d    = redirect_pc_i & ~XLEN'(3);
            fault_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FETCH_IDLE;
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    ysyx_22050612_ifu_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redirect_valid_i),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .valid_o     (head_valid),
        .head_o      (head_entry),
        .count_o     (fifo_count)
    );

    assign inst_valid_o = head_valid;
    assign inst_o       = head_valid ? head_entry.inst : NOP_INST;
    assign inst_pc_o    = head_valid ? head_entry.pc : '0;
    assign fault_o      = fault_q;
    assign fault_pc_o   = fault_pc_q;
endmodule

// File: tb/tb_ysyx_22050612_ifu.sv
// Directed bench for the fetch unit: a queue-based reference model checked every cycle,
// plus literal address/PC expectations per scenario.
module tb_ysyx_22050612_ifu;
    import ysyx_22050612_pkg::*;

    localparam int          DEPTH  = 2;
    localparam logic [63:0] NO_ERR = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        halt = 1'b0, redir = 1'b0, inst_ready = 1'b0;
    logic [63:0] rpc = '0;
    logic        inst_valid, fault;
    logic [31:0] inst;
    logic [63:0] inst_pc, fault_pc;

    ysyx_22050612_ifu_if mif();

    ysyx_22050612_ifu #(.RESET_PC(64'h8000_0000), .FIFO_DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .mem              (mif),
        .halt_i           (halt),
        .redirect_valid_i (redir),
        .redirect_pc_i    (rpc),
        .inst_valid_o     (inst_valid),
        .inst_ready_i     (inst_ready),
        .inst_o           (inst),
        .inst_pc_o        (inst_pc),
        .fault_o          (fault),
        .fault_pc_o       (fault_pc)
    );

    always #5 clk = ~clk;

    // stimulus for the next cycle, applied at the falling edge
    logic        s_rst = 1'b1, s_halt = 1'b0, s_redir = 1'b0, s_rdy = 1'b1, s_iready = 1'b1;
    logic [63:0] s_rpc = '0;
    int          lat = 1;
    logic [63:0] err_addr = NO_ERR;

    // bench memory
    logic        mem_pend = 1'b0;
    int          mem_cnt = 0;
    logic [63:0] mem_addr = '0;

    // reference model
    logic [63:0]  m_pc, m_req_pc, m_fault_pc;
    logic         m_busy, m_drop, m_fault;
    fetch_entry_t m_q[$];

    logic [63:0] hs_log[$];
    logic [63:0] dl_log[$];
    int          hs_cyc[$];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return a[31:0] ^ 32'hC3C3_0000;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_pc       = 64'h8000_0000;
        m_req_pc   = '0;
        m_fault_pc = '0;
        m_busy     = 1'b0;
        m_drop     = 1'b0;
        m_fault    = 1'b0;
        m_q.delete();
    endtask

    task automatic compare_and_step();
        logic         exp_req, exp_iv, live, do_push;
        logic [31:0]  exp_inst;
        logic [63:0]  exp_ipc;
        fetch_entry_t e;
        if (rst) model_reset();
        exp_req  = !rst && !halt && !m_fault && !redir && !m_busy && (m_q.size() < DEPTH);
        exp_iv   = (m_q.size() != 0);
        exp_inst = 32'h0000_0013;
        exp_ipc  = '0;
        if (exp_iv) begin
            exp_inst = m_q[0].inst;
            exp_ipc  = m_q[0].pc;
        end
        chk("req_valid", 64'(mif.req_valid), 64'(exp_req));
        if (exp_req) chk("req_addr", mif.req_addr, m_pc);
        chk("inst_valid", 64'(inst_valid), 64'(exp_iv));
        chk("inst", 64'(inst), 64'(exp_inst));
        chk("inst_pc", inst_pc, exp_ipc);
        chk("fault", 64'(fault), 64'(m_fault));
        if (m_fault || rst) chk("fault_pc", fault_pc, m_fault_pc);
        if (!rst) begin
            live    = m_busy && mif.rsp_valid;
            do_push = 1'b0;
            if (live) begin
                m_busy = 1'b0;
                if (!redir && !m_drop) begin
                    if (mif.rsp_err) begin
                        m_fault    = 1'b1;
                        m_fault_pc = m_req_pc;
                    end else begin
                        do_push = 1'b1;
                    end
                end
                m_drop = 1'b0;
            end
            if (exp_iv && inst_ready) void'(m_q.pop_front());
            if (do_push) begin
                e.inst = inst_of(m_req_pc);
                e.pc   = m_req_pc;
                m_q.push_back(e);
            end
            if (exp_req && mif.req_ready) begin
                m_busy   = 1'b1;
                m_req_pc = m_pc;
                m_pc     = m_pc + 64'd4;
            end
            if (redir) begin
                m_q.delete();
                m_pc    = rpc & ~64'd3;
                m_fault = 1'b0;
                if (m_busy) m_drop = 1'b1;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        rst           = s_rst;
        halt          = s_halt;
        redir         = s_redir;
        rpc           = s_rpc;
        mif.req_ready = s_rdy;
        inst_ready    = s_iready;
        mif.rsp_valid = 1'b0;
        mif.rsp_data  = '0;
        mif.rsp_err   = 1'b0;
        if (mem_pend) begin
            if (mem_cnt == 0) begin
                mif.rsp_valid = 1'b1;
                mif.rsp_data  = inst_of(mem_addr);
                mif.rsp_err   = (mem_addr == err_addr);
                mem_pend      = 1'b0;
            end else begin
                mem_cnt = mem_cnt - 1;
            end
        end
        #1;
        compare_and_step();
        if (mif.req_valid && mif.req_ready) begin
            mem_pend = 1'b1;
            mem_addr = mif.req_addr;
            mem_cnt  = lat - 1;
            hs_log.push_back(mif.req_addr);
            hs_cyc.push_back(cyc);
        end
        if (inst_valid && inst_ready) dl_log.push_back(inst_pc);
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        mem_pend = 1'b0;
        s_rst = 1'b1; s_halt = 1'b0; s_redir = 1'b0; s_rdy = 1'b1; s_iready = 1'b1;
        lat = 1; err_addr = NO_ERR;
        run(2);
        s_rst = 1'b0;
        hs_log.delete(); dl_log.delete(); hs_cyc.delete();
    endtask

    initial begin
        int n08;
        mif.req_ready = 1'b1;
        mif.rsp_valid = 1'b0;
        mif.rsp_data  = '0;
        mif.rsp_err   = 1'b0;
        model_reset();

        // reset state
        do_reset();
        chk("reset_inst", 64'(inst), 64'h13);
        chk("reset_inst_pc", inst_pc, 64'h0);
        chk("reset_req_valid", 64'(mif.req_valid), 64'h0);

        // streaming, 1-cycle latency, decode always ready
        run(8);
        chk("t1_hs0", hs_log[0], 64'h8000_0000);
        chk("t1_hs1", hs_log[1], 64'h8000_0004);
        chk("t1_hs2", hs_log[2], 64'h8000_0008);
        chk("t1_dl0", dl_log[0], 64'h8000_0000);
        chk("t1_dl1", dl_log[1], 64'h8000_0004);
        chk("t1_dl2", dl_log[2], 64'h8000_0008);
        chk("t1_issue_gap", 64'(hs_cyc[1] - hs_cyc[0]), 64'd2);

        // decode stalled: buffer fills to depth, then drains in order
        do_reset();
        s_iready = 1'b0;
        run(10);
        chk("t2_hs_count", 64'(hs_log.size()), 64'd2);
        chk("t2_head_pc", inst_pc, 64'h8000_0000);
        s_iready = 1'b1;
        run(8);
        chk("t2_dl0", dl_log[0], 64'h8000_0000);
        chk("t2_dl1", dl_log[1], 64'h8000_0004);
        chk("t2_dl2", dl_log[2], 64'h8000_0008);
        chk("t2_dl3", dl_log[3], 64'h8000_000C);

        // redirect while the fetch of 0x80000008 is in flight
        do_reset();
        run(4);
        lat = 3;
        run(2);
        s_redir = 1'b1; s_rpc = 64'h8000_0103;
        run(1);
        s_redir = 1'b0; lat = 1;
        run(8);
        chk("t3_inflight", hs_log[2], 64'h8000_0008);
        chk("t3_hs_after", hs_log[3], 64'h8000_0100);
        chk("t3_dl_after", dl_log[2], 64'h8000_0100);
        n08 = 0;
        foreach (dl_log[i]) if (dl_log[i] == 64'h8000_0008) n08++;
        chk("t3_dropped_pc", 64'(n08), 64'd0);

        // access fault on 0x80000010, cleared by redirect
        do_reset();
        err_addr = 64'h8000_0010;
        run(14);
        chk("t4_fault", 64'(fault), 64'd1);
        chk("t4_fault_pc", fault_pc, 64'h8000_0010);
        chk("t4_hs_count", 64'(hs_log.size()), 64'd5);
        s_redir = 1'b1; s_rpc = 64'h8000_0000;
        run(1);
        s_redir = 1'b0; err_addr = NO_ERR;
        run(4);
        chk("t4_fault_clr", 64'(fault), 64'd0);
        chk("t4_resume", hs_log[5], 64'h8000_0000);

        // halt right after a handshake
        do_reset();
        run(1);
        s_halt = 1'b1;
        run(6);
        chk("t5_hs_halted", 64'(hs_log.size()), 64'd1);
        chk("t5_delivered", dl_log[0], 64'h8000_0000);
        s_halt = 1'b0;
        run(4);
        chk("t5_resume", hs_log[1], 64'h8000_0004);

        // reset while a request is outstanding; stray response afterwards
        do_reset();
        lat = 2;
        run(1);
        s_rst = 1'b1;
        run(1);
        s_rst = 1'b0; s_rdy = 1'b0;
        run(1);
        s_rdy = 1'b1; lat = 1;
        run(1);
        chk("t6_no_stray", 64'(inst_valid), 64'd0);
        chk("t6_first_req", hs_log[1], 64'h8000_0000);
        run(3);
        chk("t6_dl_count", 64'(dl_log.size()), 64'd1);
        chk("t6_dl0", dl_log[0], 64'h8000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
